// File: rtl/alu_result_sel_q_pkg.sv
// Shared opcode constants and flag bundle for the ALU result-select queue.
// The queue entry pairs a WIDTH-bit result with this flag bundle.
package alu_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_ADD = 3'b110;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_result_sel_q_if.sv
// Handshake bundle between the ALU function units, the select queue
// and the writeback stage; master drives operands, slave is the queue.
interface alu_result_sel_q_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       select;
    logic [WIDTH-1:0] mov_res;
    logic [WIDTH-1:0] not_res;
    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] add_res;
    logic             add_cout;
    logic             sub_borrow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_illegal;

    modport master (
        output in_valid, select, mov_res, not_res, and_res, or_res,
        output sub_res, add_res, add_cout, sub_borrow, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_zero, out_neg, out_carry, out_illegal
    );

    modport slave (
        input  in_valid, select, mov_res, not_res, and_res, or_res,
        input  sub_res, add_res, add_cout, sub_borrow, out_ready,
        output in_ready, out_valid, out_result,
        output out_zero, out_neg, out_carry, out_illegal
    );
endinterface

// File: rtl/alu_result_sel_q_fifo.sv
// Generic DEPTH-entry synchronous FIFO; head slot is read straight
// from storage so the output is registered with no push-cycle bypass.
module alu_res_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_sel_q.sv
// ALU result select with flag generation feeding a small output queue.
// Define ALU_SEL_ERRCNT_EN to add the saturating illegal-opcode counter.
module alu_result_sel_q
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    alu_result_sel_q_if.slave bus
`ifdef ALU_SEL_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_t       flags;
    } entry_t;

    entry_t sel;
    entry_t head;
    logic   push;
    logic   pop;
    logic   full;
    logic   empty;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_cfg_err
        $error("alu_result_sel_q: bad DEPTH or CNT_W");
    end

    // Illegal opcodes leave result at zero, so zero=1/neg=0 fall out naturally.
    always_comb begin
        sel = '0;
        unique case (bus.select)
            OP_MOV: sel.result = bus.mov_res;
            OP_NOT: sel.result = bus.not_res;
            OP_AND: sel.result = bus.and_res;
            OP_OR:  sel.result = bus.or_res;
            OP_SUB: begin
                sel.result      = bus.sub_res;
                sel.flags.carry = bus.sub_borrow;
            end
            OP_ADD: begin
                sel.result      = bus.add_res;
                sel.flags.carry = bus.add_cout;
            end
            default: sel.flags.illegal = 1'b1;
        endcase
        sel.flags.zero = (sel.result == '0);
        sel.flags.neg  = sel.result[WIDTH-1];
    end

    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = bus.out_ready && !empty;

    alu_res_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (sel),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid   = !empty;
    assign bus.out_result  = head.result;
    assign bus.out_zero    = head.flags.zero;
    assign bus.out_neg     = head.flags.neg;
    assign bus.out_carry   = head.flags.carry;
    assign bus.out_illegal = head.flags.illegal;

`ifdef ALU_SEL_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (push && sel.flags.illegal && err_count != '1) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_sel_q.sv
// Directed scoreboard bench for alu_result_sel_q (WIDTH=8, DEPTH=2);
// counter checks are compiled in when ALU_SEL_ERRCNT_EN is defined.
module tb_alu_result_sel_q;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         c;
        logic         i;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_result_sel_q_if #(.WIDTH(W)) bus ();

`ifdef ALU_SEL_ERRCNT_EN
    logic [CW-1:0] err_count;
    int            exp_err = 0;
`endif

    alu_result_sel_q #(
        .WIDTH (W),
        .DEPTH (2),
        .CNT_W (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_SEL_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    exp_t       sb [$];
    int         total = 0;
    int         bad   = 0;
    int         pops  = 0;
    logic       last_push = 1'b0;
    logic [2:0] legal_ops [6] = '{OP_MOV, OP_NOT, OP_AND, OP_OR, OP_SUB, OP_ADD};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        e = '{r: '0, z: 1'b0, n: 1'b0, c: 1'b0, i: 1'b0};
        case (bus.select)
            3'b000: e.r = bus.mov_res;
            3'b001: e.r = bus.not_res;
            3'b011: e.r = bus.and_res;
            3'b100: e.r = bus.or_res;
            3'b101: begin e.r = bus.sub_res; e.c = bus.sub_borrow; end
            3'b110: begin e.r = bus.add_res; e.c = bus.add_cout; end
            default: e.i = 1'b1;
        endcase
        e.z = (e.r == 8'h00);
        e.n = e.i ? 1'b0 : e.r[7];
        return e;
    endfunction

    task automatic set_op(input logic [2:0] op, input logic [7:0] v,
                          input logic co, input logic bo);
        bus.select     = op;
        bus.mov_res    = 8'($urandom);
        bus.not_res    = 8'($urandom);
        bus.and_res    = 8'($urandom);
        bus.or_res     = 8'($urandom);
        bus.sub_res    = 8'($urandom);
        bus.add_res    = 8'($urandom);
        bus.add_cout   = co;
        bus.sub_borrow = bo;
        case (op)
            3'b000: bus.mov_res = v;
            3'b001: bus.not_res = v;
            3'b011: bus.and_res = v;
            3'b100: bus.or_res  = v;
            3'b101: bus.sub_res = v;
            3'b110: bus.add_res = v;
            default: ;
        endcase
    endtask

    task automatic step();
        exp_t e;
        exp_t m;
        @(negedge clk);
        last_push = 1'b0;
        if (!rst && bus.out_valid && bus.out_ready) begin
            pops++;
            chk("pop_has_exp", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q_result", bus.out_result, e.r);
                chk("q_zero", bus.out_zero, e.z);
                chk("q_neg", bus.out_neg, e.n);
                chk("q_carry", bus.out_carry, e.c);
                chk("q_illegal", bus.out_illegal, e.i);
            end
        end
        if (!rst && bus.in_valid && bus.in_ready) begin
            m = model();
            sb.push_back(m);
            last_push = 1'b1;
`ifdef ALU_SEL_ERRCNT_EN
            if (m.i && exp_err < (1 << CW) - 1) exp_err++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] hold_r;
        logic [3:0]   hold_f;
        int           guard;
        int           pops0;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_op(OP_MOV, 8'h00, 1'b0, 1'b0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_result", bus.out_result, 0);
        chk("rst_flags", {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_illegal}, 0);
`ifdef ALU_SEL_ERRCNT_EN
        chk("rst_err_count", err_count, 0);
`endif

        // add producing zero with carry, one-cycle latency
        bus.out_ready = 1'b1;
        set_op(OP_ADD, 8'h00, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("lat_valid", bus.out_valid, 1);
        chk("add_result", bus.out_result, 8'h00);
        chk("add_zero", bus.out_zero, 1);
        chk("add_carry", bus.out_carry, 1);
        chk("add_neg", bus.out_neg, 0);
        step();
        chk("empty_after_pop", bus.out_valid, 0);

        // sub with borrow, then not ignoring add_cout
        set_op(OP_SUB, 8'h80, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        step();
        chk("sub_result", bus.out_result, 8'h80);
        chk("sub_neg", bus.out_neg, 1);
        chk("sub_carry", bus.out_carry, 1);
        set_op(OP_NOT, 8'h7F, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("not_result", bus.out_result, 8'h7F);
        chk("not_neg", bus.out_neg, 0);
        chk("not_carry", bus.out_carry, 0);
        repeat (2) step();

        // backpressure: three ops into a two-entry queue
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_op(OP_OR, 8'h3C, 1'b0, 1'b0);
        step();
        set_op(OP_AND, 8'h00, 1'b1, 1'b1);
        step();
        chk("full_in_ready", bus.in_ready, 0);
        hold_r = bus.out_result;
        hold_f = {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_illegal};
        set_op(OP_MOV, 8'hA5, 1'b1, 1'b0);
        repeat (3) begin
            step();
            chk("held_in_ready", bus.in_ready, 0);
            chk("stable_result", bus.out_result, hold_r);
            chk("stable_flags", {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_illegal}, hold_f);
        end
        chk("third_held", sb.size(), 2);
        bus.out_ready = 1'b1;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!last_push && guard < 10);
        chk("third_accepted", last_push, 1);
        bus.in_valid = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("drain3_empty", sb.size(), 0);

        // full queue, then continuous streaming for 10 cycles
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (2) begin
            set_op(legal_ops[$urandom_range(0, 5)], 8'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        bus.out_ready = 1'b1;
        pops0 = pops;
        set_op(legal_ops[$urandom_range(0, 5)], 8'($urandom), 1'($urandom), 1'($urandom));
        repeat (10) begin
            step();
            if (last_push)
                set_op(legal_ops[$urandom_range(0, 5)], 8'($urandom), 1'($urandom), 1'($urandom));
        end
        chk("stream_pops", pops - pops0, 10);
        bus.in_valid = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("stream_drain", sb.size(), 0);

        // illegal opcodes
        bus.in_valid = 1'b1;
        set_op(3'b010, 8'hFF, 1'b1, 1'b1);
        step();
        chk("ill010_result", bus.out_result, 8'h00);
        chk("ill010_illegal", bus.out_illegal, 1);
        chk("ill010_zero", bus.out_zero, 1);
        chk("ill010_carry", bus.out_carry, 0);
        set_op(3'b111, 8'hFF, 1'b1, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("ill111_result", bus.out_result, 8'h00);
        chk("ill111_illegal", bus.out_illegal, 1);
        chk("ill111_zero", bus.out_zero, 1);
        chk("ill111_carry", bus.out_carry, 0);
        step();
`ifdef ALU_SEL_ERRCNT_EN
        chk("err_count_2", err_count, 2);
`endif
        bus.in_valid = 1'b1;
        repeat (3) step();
        bus.in_valid = 1'b0;
        repeat (2) step();
        chk("ill_drain", sb.size(), 0);
`ifdef ALU_SEL_ERRCNT_EN
        chk("err_count_sat", err_count, 3);
        chk("err_count_model", err_count, exp_err);
`endif

        // reset while holding two entries and in_valid high
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_op(OP_MOV, 8'h11, 1'b0, 1'b0);
        step();
        set_op(OP_ADD, 8'h22, 1'b1, 1'b0);
        step();
        chk("pre_rst_full", bus.in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
`ifdef ALU_SEL_ERRCNT_EN
        exp_err = 0;
        chk("midrst_err_count", err_count, 0);
`endif
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_result", bus.out_result, 0);
        bus.in_valid = 1'b0;
        step();
        chk("midrst_nothing_queued", bus.out_valid, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
